// File: rtl/l1_tlb_repl_state_pkg.sv
// Shared L1 TLB replacement definitions: geometry, PLRU node indices and the
// single-way tree touch used by both the state keeper and the victim selector.
package tlb_pkg;

  localparam int NWAYS_L1 = 8;
  localparam int WAY_W    = 3;

  // Node 1 is the root; children of node n are {n,0} and {n,1}.
  localparam logic [2:0] PLRU_ROOT    = 3'd1;
  localparam logic [1:0] PLRU_L1_BASE = 2'b01;  // level-1 nodes {1,b2}
  localparam logic [0:0] PLRU_L2_BASE = 1'b1;   // level-2 nodes {1,b2,b1}

  // Point every node on the path to `way` away from it; bit 0 is never used.
  function automatic logic [7:0] plru_touch(input logic [7:0] state,
                                            input logic [WAY_W-1:0] way);
    logic [7:0] s;
    logic [2:0] n_l1;
    logic [2:0] n_l2;
    s       = state;
    n_l1    = {PLRU_L1_BASE, way[2]};
    n_l2    = {PLRU_L2_BASE, way[2], way[1]};
    s[PLRU_ROOT] = ~way[2];
    s[n_l1]      = ~way[1];
    s[n_l2]      = ~way[0];
    s[0]         = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/l1_tlb_repl_state_touch.sv
// Combinational PLRU update applying an optional hit touch followed by an
// optional refill touch, so the refill wins on any node both paths share.
module plru_touch_unit
  import tlb_pkg::*;
(
  input  logic [7:0]       state_i,
  input  logic             hit_en_i,
  input  logic [WAY_W-1:0] hit_way_i,
  input  logic             ref_en_i,
  input  logic [WAY_W-1:0] ref_way_i,
  output logic [7:0]       state_o
);

  // Ordered touches: hit first, refill second.
  always_comb begin
    state_o = state_i;
    if (hit_en_i) state_o = plru_touch(state_o, hit_way_i);
    if (ref_en_i) state_o = plru_touch(state_o, ref_way_i);
    state_o[0] = 1'b0;
  end

endmodule

// File: rtl/l1_tlb_repl_state.sv
// L1 TLB replacement state: per-way valid bits and 7-node tree-PLRU,
// updated by lookup hits, refills, invalidates and flushes.
//
// Refill protocol: a refill request (refill_valid) is always accepted on the
// clock edge unless flush is high in the same cycle; accepted refills answer
// with refill_ack high for exactly the following cycle. There is no ready.
module l1_tlb_repl_state
  import tlb_pkg::*;
#(
  parameter int NWAYS     = 8,
  parameter int TOUCH_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hit_valid,
  input  logic [WAY_W-1:0] hit_way,
  input  logic             refill_valid,
  input  logic [WAY_W-1:0] refill_way,
  output logic             refill_ack,
  input  logic             inv_valid,
  input  logic [7:0]       inv_mask,
  input  logic             flush,
  output logic [7:0]       valid,
  output logic [7:0]       plru_val,
  output logic             all_valid
);

  if (NWAYS != NWAYS_L1) begin : g_bad_nways
    $error("l1_tlb_repl_state: only NWAYS=8 is supported");
  end
  if (TOUCH_LAT != 0 && TOUCH_LAT != 1) begin : g_bad_lat
    $error("l1_tlb_repl_state: TOUCH_LAT must be 0 or 1");
  end

  logic [7:0]       valid_q, valid_d;
  logic [7:0]       plru_q, plru_d;
  logic             ack_q, ack_d;
  logic             all_valid_q, all_valid_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WAY_W-1:0] pend_way_q, pend_way_d;

  logic             touch_hit_en;
  logic [WAY_W-1:0] touch_hit_way;
  logic             touch_ref_en;
  logic [7:0]       refill_set;

  // Select the hit touch source (delayed or direct) and gate everything on flush.
  always_comb begin
    touch_hit_en  = 1'b0;
    touch_hit_way = '0;
    pend_valid_d  = 1'b0;
    pend_way_d    = pend_way_q;
    if (TOUCH_LAT == 1) begin
      touch_hit_en  = pend_valid_q & ~flush;
      touch_hit_way = pend_way_q;
      pend_valid_d  = hit_valid & ~flush;
      if (hit_valid) pend_way_d = hit_way;
    end else begin
      touch_hit_en  = hit_valid & ~flush;
      touch_hit_way = hit_way;
    end
    touch_ref_en = refill_valid & ~flush;
  end

  plru_touch_unit u_touch (
    .state_i   (plru_q),
    .hit_en_i  (touch_hit_en),
    .hit_way_i (touch_hit_way),
    .ref_en_i  (touch_ref_en),
    .ref_way_i (refill_way),
    .state_o   (plru_d)
  );

  // Valid vector: refill sets, invalidate clears after it, flush clears all.
  always_comb begin
    refill_set = 8'b0;
    refill_set[refill_way] = refill_valid;
    valid_d = (valid_q | refill_set) & ~(inv_valid ? inv_mask : 8'b0);
    if (flush) valid_d = 8'b0;
    all_valid_d = &valid_d;
    ack_d       = touch_ref_en;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q      <= 8'b0;
      plru_q       <= 8'b0;
      ack_q        <= 1'b0;
      all_valid_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_way_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      plru_q       <= plru_d;
      ack_q        <= ack_d;
      all_valid_q  <= all_valid_d;
      pend_valid_q <= pend_valid_d;
      pend_way_q   <= pend_way_d;
    end
  end

  assign valid      = valid_q;
  assign plru_val   = plru_q;
  assign refill_ack = ack_q;
  assign all_valid  = all_valid_q;

endmodule

// File: tb/tb_l1_tlb_repl_state.sv
// Bench for l1_tlb_repl_state (TOUCH_LAT=1): directed scenarios plus random
// traffic, checked against a path-walking tree model through an expected queue.
module tb_l1_tlb_repl_state;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       hit_valid = 1'b0;
  logic [2:0] hit_way = 3'd0;
  logic       refill_valid = 1'b0;
  logic [2:0] refill_way = 3'd0;
  logic       refill_ack;
  logic       inv_valid = 1'b0;
  logic [7:0] inv_mask = 8'h00;
  logic       flush = 1'b0;
  logic [7:0] valid;
  logic [7:0] plru_val;
  logic       all_valid;

  l1_tlb_repl_state #(.NWAYS(8), .TOUCH_LAT(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hit_valid    (hit_valid),
    .hit_way      (hit_way),
    .refill_valid (refill_valid),
    .refill_way   (refill_way),
    .refill_ack   (refill_ack),
    .inv_valid    (inv_valid),
    .inv_mask     (inv_mask),
    .flush        (flush),
    .valid        (valid),
    .plru_val     (plru_val),
    .all_valid    (all_valid)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_valid[8];
  bit m_node[8];     // tree nodes 1..7
  bit m_ack;
  int m_pend[$];     // hit touches waiting one edge

  function automatic void m_touch(input int w);
    int n = 1;
    for (int lvl = 2; lvl >= 0; lvl--) begin
      int b = (w >> lvl) & 1;
      m_node[n] = (b == 0);   // point away from the touched way
      n = 2 * n + b;
    end
  endfunction

  function automatic logic [7:0] m_valid_vec();
    logic [7:0] v = 8'h00;
    for (int i = 0; i < 8; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic logic [7:0] m_plru_vec();
    logic [7:0] v = 8'h00;
    for (int i = 1; i < 8; i++) v[i] = m_node[i];
    return v;
  endfunction

  function automatic int victim(input logic [7:0] p);
    int n = 1;
    repeat (3) n = 2 * n + int'(p[n]);
    return n - 8;
  endfunction

  function automatic void m_step(input bit rst, input bit hv, input int hw, input bit rv,
                                 input int rw, input bit iv, input logic [7:0] im, input bit fl);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_node[i] = 0; end
      m_pend.delete();
      m_ack = 0;
    end else if (fl) begin
      for (int i = 0; i < 8; i++) m_valid[i] = 0;
      m_pend.delete();
      m_ack = 0;
    end else begin
      if (m_pend.size() > 0) m_touch(m_pend.pop_front());
      if (hv) m_pend.push_back(hw);
      if (rv) begin m_touch(rw); m_valid[rw] = 1; end
      if (iv) for (int i = 0; i < 8; i++) if (im[i]) m_valid[i] = 0;
      m_ack = rv;
    end
  endfunction

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input bit hv, input int hw, input bit rv, input int rw,
                       input bit iv, input logic [7:0] im, input bit fl);
    logic [7:0] mv;
    @(negedge clk);
    reset_n      = ~rst;
    hit_valid    = hv;
    hit_way      = hw[2:0];
    refill_valid = rv;
    refill_way   = rw[2:0];
    inv_valid    = iv;
    inv_mask     = im;
    flush        = fl;
    m_step(rst, hv, hw, rv, rw, iv, im, fl);
    mv = m_valid_vec();
    exp_q.push_back({mv, m_plru_vec(), m_ack, &mv});
  endtask

  task automatic idle();  drive(0, 0, 0, 0, 0, 0, 8'h00, 0); endtask
  task automatic rst1();  drive(1, 0, 0, 0, 0, 0, 8'h00, 0); endtask
  task automatic hit(input int w);    drive(0, 1, w, 0, 0, 0, 8'h00, 0); endtask
  task automatic refill(input int w); drive(0, 0, 0, 1, w, 0, 8'h00, 0); endtask

  // Wait until just after the edge that consumes the last driven inputs.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [17:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle_state{valid,plru,ack,all_valid}",
              {14'd0, valid, plru_val, refill_ack, all_valid}, {14'd0, e});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int order[8] = '{0, 2, 4, 6, 1, 3, 5, 7};
    logic [7:0] plru_before;
    int wait_cnt;

    rst1(); rst1();
    settle();
    check("reset_valid", valid, 8'h00);
    check("reset_plru", plru_val, 8'h00);
    check("reset_ack", refill_ack, 1'b0);

    // Delayed hit touch of way 0.
    hit(0); settle();
    check("hit_lat_hold", plru_val, 8'h00);
    idle(); settle();
    check("hit0_plru", plru_val, 8'h16);
    check("hit0_victim", victim(plru_val), 4);

    // Fill every way back to back.
    rst1();
    for (int w = 0; w < 8; w++) begin
      refill(w); settle();
      check("refill_ack_pulse", refill_ack, 1'b1);
    end
    check("fill_valid", valid, 8'hFF);
    check("fill_all_valid", all_valid, 1'b1);
    idle(); settle();
    check("ack_drops", refill_ack, 1'b0);

    // Leave PLRU at zero with all ways valid.
    for (int i = 0; i < 8; i++) refill(order[i]);
    settle();
    check("plru_zeroed", plru_val, 8'h00);

    // Pending hit of way 5 applied together with a refill of way 0.
    hit(5); refill(0); settle();
    check("hit_refill_order", plru_val, 8'h1E);

    // Invalidate wins over refill on way 2.
    drive(0, 0, 0, 1, 2, 1, 8'h24, 0); settle();
    check("inv_refill_valid", valid, 8'hDB);
    check("inv_refill_all_valid", all_valid, 1'b0);
    check("inv_refill_ack", refill_ack, 1'b1);

    // Flush with a pending hit and a same-cycle refill.
    refill(2); refill(5); hit(3);
    plru_before = m_plru_vec();
    drive(0, 0, 0, 1, 4, 0, 8'h00, 1); settle();
    check("flush_valid", valid, 8'h00);
    check("flush_ack", refill_ack, 1'b0);
    check("flush_plru", plru_val, plru_before);
    idle(); settle();
    check("flush_pending_dropped", plru_val, plru_before);

    // Reset with a pending touch and valid=0x0F.
    rst1();
    for (int w = 0; w < 4; w++) refill(w);
    hit(6);
    rst1(); settle();
    check("midrst_valid", valid, 8'h00);
    check("midrst_plru", plru_val, 8'h00);
    check("midrst_ack", refill_ack, 1'b0);
    check("midrst_all_valid", all_valid, 1'b0);
    idle(); settle();
    check("midrst_no_late_touch", plru_val, 8'h00);

    // Random traffic.
    for (int c = 0; c < 500; c++) begin
      bit r  = ($urandom_range(0, 99) < 3);
      bit fl = ($urandom_range(0, 99) < 5);
      bit iv = ($urandom_range(0, 99) < 20);
      drive(r, $urandom_range(0, 1), $urandom_range(0, 7),
            ($urandom_range(0, 99) < 60), $urandom_range(0, 7),
            iv, 8'($urandom_range(0, 255)), fl);
    end
    idle(); idle();

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #3;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/l1_tlb_repl_state.md
Name: l1_tlb_repl_state

Overview:
- State-keeping counterpart of the L1 TLB victim selector.
- Holds the 8-entry valid vector and the 7-node tree-PLRU state. Updates them on lookup hits, refills, single-entry invalidates and full flushes.
- Drives `valid`/`plru_val` into the combinational victim selector. The selector returns `repl_waddr` for refills.
- Sits beside the 8-way fully-associative L1 TLB array, clocked with the TLB pipeline.

Parameters:
- NWAYS, 8, number of TLB ways. Only 8 is supported; elaboration fails on any other value.
- TOUCH_LAT, 1, cycles from `hit_valid` to the PLRU update. Legal values are 0 and 1.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- hit_valid  in  1  lookup hit this cycle
- hit_way  in  3  way that hit
- refill_valid  in  1  refill write request
- refill_way  in  3  way being written (normally the selector's `repl_waddr`)
- refill_ack  out  1  one-cycle pulse: refill committed
- inv_valid  in  1  invalidate request
- inv_mask  in  8  ways to invalidate
- flush  in  1  invalidate all ways
- valid  out  8  per-way valid; bit i = way i
- plru_val  out  8  PLRU tree; bits 7:1 = nodes 7..1, bit 0 always 0
- all_valid  out  1  &valid, registered alongside `valid`

Behaviour:
- **Reset** (reset_n=0 at a clk edge):
  - valid=0, plru_val=0, refill_ack=0, all_valid=0.
  - The pending-touch register is cleared.
  - Requests in the reset cycle are dropped.
  - Reset mid-operation discards any pending touch or ack.
- **Tree encoding.** Node 1 is the root. Children of node n are {n,0} and {n,1}. Leaf way = low 3 bits of the 4-bit path.
- **Touch of way w = b2b1b0** writes, on the selected path:
  - plru[1] = ~b2
  - plru[{1,b2}] = ~b1
  - plru[{1,b2,b1}] = ~b0
  - All other nodes are unchanged.
  - Result: the selector's walk leads away from w.
- **Hit touch.**
  - TOUCH_LAT=1: hit_valid/hit_way are captured in a pending register. The touch is applied at the next edge, so plru_val changes 2 edges after the hit is presented.
  - TOUCH_LAT=0: the touch is applied at the same edge as the hit.
  - Hits do not change valid.
- **Refill.** Accepted every cycle unless flush=1. At the edge:
  - valid[refill_way]=1
  - touch refill_way
  - refill_ack=1 for exactly the following cycle.
- **Invalidate.** At the edge, valid &= ~inv_mask. PLRU is untouched.
- **Flush.** At the edge:
  - valid=0 and the pending hit touch is discarded.
  - An accepted refill in the same cycle is dropped, with no ack.
  - PLRU is untouched.
- **Same-edge ordering**, applied in sequence:
  1. Pending/direct hit touch.
  2. Refill touch. On a shared node, the refill value wins.
  3. For valid: refill set first, then invalidate clear. Invalidate wins on the same way.
  4. Flush overrides everything.
- A hit and a refill to the same way in one cycle yields a single consistent touch.
- All outputs are registered. No combinational path from inputs to outputs.
- **Out-of-range way.** None is possible, since way inputs are 3-bit. plru_val[0] is never written.

Decomposition:
- Shared package `tlb_pkg`:
  - NWAYS_L1=8, WAY_W=3
  - PLRU node-index constants
  - function `plru_touch(state[7:0], way[2:0]) -> state[7:0]`
- The selector uses the same package.
- One natural sub-module, `plru_touch_unit`: combinational, applies up to two ordered touches (hit, then refill) to the current state. It is instantiated once.

Test Plan:
- Reset, then hit_way=0 with TOUCH_LAT=1 → plru_val stays 0x00 one edge later, then becomes 0x16. Selector walk now yields way 4.
- From reset: refill ways 0..7 in consecutive cycles → each refill_ack pulses one cycle after its refill. After the last one, valid=0xFF and all_valid=1.
- valid=0xFF, plru=0x00: same-cycle hit_way=5 and refill_way=0 → touch 5 applied first, refill touch 0 wins shared node 1, plru_val=0x1E.
- valid=0xFF: inv_mask=0x24 with refill_way=2 in the same cycle → valid=0xDB, all_valid=0, refill_ack=1.
- valid=0xFF, pending hit: flush with refill_valid=1 → valid=0x00, refill_ack stays 0, plru_val unchanged, pending touch dropped.
- Pending touch and valid=0x0F: assert reset_n=0 for one cycle → all outputs 0 next cycle, no late PLRU change.
